// File: rtl/sobel_pkg.sv
// Shared constants for the 3x3 Sobel window generator: kernel geometry and
// row-major window slot indices (TL = top-left ... BR = bottom-right).
package sobel_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned KSIZE      = 3;
  localparam int unsigned WIN_N      = KSIZE * KSIZE;

  localparam int unsigned WIN_TL = 0;
  localparam int unsigned WIN_TC = 1;
  localparam int unsigned WIN_TR = 2;
  localparam int unsigned WIN_ML = 3;
  localparam int unsigned WIN_MC = 4;
  localparam int unsigned WIN_MR = 5;
  localparam int unsigned WIN_BL = 6;
  localparam int unsigned WIN_BC = 7;
  localparam int unsigned WIN_BR = 8;

endpackage

// File: rtl/sobel_line_buf.sv
// One image line of pixel storage with a registered (1-cycle) read port.
// A read and a write at the same address in one cycle returns the old content.
module sobel_line_buf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 640
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DATA_W-1:0]        rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;

  // Storage is deliberately never reset; the first two lines of a frame refill it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-order pixel stream to 3x3 neighbourhood windows, one window per accepted
// pixel at row>=2, col>=2, presented one cycle after that pixel.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pix_i,
  input  logic              valid_i,
  input  logic              sof_i,
  output logic [DATA_W-1:0] d0_o,
  output logic [DATA_W-1:0] d1_o,
  output logic [DATA_W-1:0] d2_o,
  output logic [DATA_W-1:0] d3_o,
  output logic [DATA_W-1:0] d4_o,
  output logic [DATA_W-1:0] d5_o,
  output logic [DATA_W-1:0] d6_o,
  output logic [DATA_W-1:0] d7_o,
  output logic [DATA_W-1:0] d8_o,
  output logic              valid_o,
  output logic              eof_o
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);
  localparam logic [CW-1:0] ColWin  = CW'(KSIZE - 1);
  localparam logic [RW-1:0] RowWin  = RW'(KSIZE - 1);

  logic [CW-1:0]     col_q, col_d, col_cur;
  logic [RW-1:0]     row_q, row_d, row_cur;
  logic              win_ok, eof_d;
  logic              valid_q, eof_q;
  logic [DATA_W-1:0] lb_r1_rd, lb_r2_rd;
  logic [DATA_W-1:0] win_q [WIN_N];
  logic [DATA_W-1:0] win_d [WIN_N];
  logic [DATA_W-1:0] out_q [WIN_N];

  always_comb begin
    col_cur = sof_i ? '0 : col_q;
    row_cur = sof_i ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (valid_i) begin
      if (col_cur == ColLast) begin
        col_d = '0;
        row_d = (row_cur == RowLast) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
    end
    win_ok = valid_i && (col_cur >= ColWin) && (row_cur >= RowWin);
    eof_d  = win_ok && (col_cur == ColLast) && (row_cur == RowLast);
  end

  // Reads are issued at the next column so the line data is already registered
  // when that pixel arrives; the write of the current column never collides.
  sobel_line_buf #(
    .DATA_W(DATA_W),
    .DEPTH (IMG_W)
  ) u_lb_r1 (
    .clk_i    (clk),
    .we_i     (valid_i),
    .wr_addr_i(col_cur),
    .wr_data_i(pix_i),
    .rd_addr_i(col_d),
    .rd_data_o(lb_r1_rd)
  );

  sobel_line_buf #(
    .DATA_W(DATA_W),
    .DEPTH (IMG_W)
  ) u_lb_r2 (
    .clk_i    (clk),
    .we_i     (valid_i),
    .wr_addr_i(col_cur),
    .wr_data_i(lb_r1_rd),
    .rd_addr_i(col_d),
    .rd_data_o(lb_r2_rd)
  );

  always_comb begin
    win_d = win_q;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++) begin
        win_d[r * KSIZE + c] = win_q[r * KSIZE + c + 1];
      end
    end
    win_d[WIN_TR] = lb_r2_rd;
    win_d[WIN_MR] = lb_r1_rd;
    win_d[WIN_BR] = pix_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      win_q   <= '{default: '0};
      out_q   <= '{default: '0};
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= win_ok;
      eof_q   <= eof_d;
      if (valid_i) begin
        win_q <= win_d;
      end
      // Separate output copy so d*_o only move when a real window is presented.
      if (win_ok) begin
        out_q <= win_d;
      end
    end
  end

  assign d0_o    = out_q[WIN_TL];
  assign d1_o    = out_q[WIN_TC];
  assign d2_o    = out_q[WIN_TR];
  assign d3_o    = out_q[WIN_ML];
  assign d4_o    = out_q[WIN_MC];
  assign d5_o    = out_q[WIN_MR];
  assign d6_o    = out_q[WIN_BL];
  assign d7_o    = out_q[WIN_BC];
  assign d8_o    = out_q[WIN_BR];
  assign valid_o = valid_q;
  assign eof_o   = eof_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 image: a raster model pushes the
// expected window whenever a pixel is driven; outputs are popped and compared.
module tb_sobel_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;

  localparam logic [71:0] WinFirst = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
  localparam logic [71:0] WinLast  = {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16};
  localparam logic [71:0] WinF2    = {8'd101, 8'd102, 8'd103, 8'd105, 8'd106, 8'd107,
                                      8'd109, 8'd110, 8'd111};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] pix_i = '0;
  logic          valid_i = 1'b0;
  logic          sof_i = 1'b0;
  logic [DW-1:0] d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
  logic          valid_o, eof_o;

  sobel_window_gen #(
    .DATA_W(DW),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_i  (pix_i),
    .valid_i(valid_i),
    .sof_i  (sof_i),
    .d0_o   (d0_o),
    .d1_o   (d1_o),
    .d2_o   (d2_o),
    .d3_o   (d3_o),
    .d4_o   (d4_o),
    .d5_o   (d5_o),
    .d6_o   (d6_o),
    .d7_o   (d7_o),
    .d8_o   (d8_o),
    .valid_o(valid_o),
    .eof_o  (eof_o)
  );

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  logic [72:0]   exp_q[$];
  logic [71:0]   seen[$];
  logic [DW-1:0] img[H][W];
  int            mr = 0;
  int            mc = 0;
  logic [71:0]   last_d = '0;
  logic          last_eof = 1'b0;
  int            eof_cnt = 0;

  task automatic step(input logic v, input logic s, input logic [DW-1:0] p);
    logic        exp_v;
    logic [72:0] e;
    logic [72:0] obs;
    valid_i = v;
    sof_i   = s;
    pix_i   = p;
    exp_v   = 1'b0;
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
        exp_v = 1'b1;
        e = {(mr == H - 1 && mc == W - 1),
             img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
             img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
             img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
        exp_q.push_back(e);
      end
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
        mc = mc + 1;
      end
    end
    @(posedge clk);
    #1;
    obs = {eof_o, d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o};
    checks++;
    assert (valid_o === exp_v) else begin
      errors++;
      $error("FAIL valid_o: got %b want %b (pix %0d)", valid_o, exp_v, p);
    end
    if (valid_o === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL scoreboard_empty: got window %h want none", obs);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
          errors++;
          $error("FAIL window: got %h want %h", obs, e);
        end
      end
      seen.push_back(obs[71:0]);
      last_d   = obs[71:0];
      last_eof = obs[72];
      if (obs[72]) eof_cnt++;
    end else begin
      checks++;
      assert (obs === {1'b0, last_d}) else begin
        errors++;
        $error("FAIL hold: got %h want %h", obs, {1'b0, last_d});
      end
    end
  endtask

  task automatic do_reset();
    logic [73:0] obs;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    sof_i   = 1'b0;
    pix_i   = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
      obs = {valid_o, eof_o, d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o};
      checks++;
      assert (obs === 74'd0) else begin
        errors++;
        $error("FAIL reset_outputs: got %h want 0", obs);
      end
    end
    rst_n  = 1'b1;
    mr     = 0;
    mc     = 0;
    last_d = '0;
    exp_q.delete();
  endtask

  task automatic begin_phase();
    seen.delete();
    eof_cnt = 0;
  endtask

  task automatic end_phase(input string tag, input int want_wins, input int want_eof);
    step(1'b0, 1'b0, '0);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s_pending: got %0d want 0", tag, exp_q.size());
    end
    checks++;
    assert (seen.size() == want_wins) else begin
      errors++;
      $error("FAIL %s_windows: got %0d want %0d", tag, seen.size(), want_wins);
    end
    checks++;
    assert (eof_cnt == want_eof) else begin
      errors++;
      $error("FAIL %s_eof_count: got %0d want %0d", tag, eof_cnt, want_eof);
    end
  endtask

  task automatic send_frame(input int base, input logic first_sof);
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, first_sof && (i == 0), DW'(base + i + 1));
    end
  endtask

  task automatic check_win(input string tag, input logic [71:0] got, input logic [71:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  initial begin
    do_reset();

    // Continuous 4x4 frame
    begin_phase();
    send_frame(0, 1'b1);
    end_phase("cont", 4, 1);
    check_win("cont_first", seen[0], WinFirst);
    check_win("cont_last", seen[3], WinLast);
    checks++;
    assert (last_eof === 1'b1) else begin
      errors++;
      $error("FAIL cont_last_eof: got %b want 1", last_eof);
    end

    // Same frame with random idle cycles between pixels
    begin_phase();
    for (int i = 0; i < W * H; i++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, DW'($urandom_range(0, 255)));
      step(1'b1, i == 0, DW'(i + 1));
    end
    end_phase("gappy", 4, 1);
    check_win("gappy_first", seen[0], WinFirst);
    check_win("gappy_last", seen[3], WinLast);

    // Two frames back-to-back, sof only on the first
    begin_phase();
    send_frame(0, 1'b1);
    send_frame(100, 1'b0);
    end_phase("b2b", 8, 2);
    check_win("b2b_f2_first", seen[4], WinF2);

    // Frame aborted by sof at its 7th pixel
    begin_phase();
    for (int i = 0; i < 6; i++) step(1'b1, i == 0, DW'(50 + i));
    send_frame(0, 1'b1);
    end_phase("sof_abort", 4, 1);
    check_win("sof_abort_first", seen[0], WinFirst);
    check_win("sof_abort_last", seen[3], WinLast);

    // Reset mid-frame after pixel 10, then a fresh frame without sof
    begin_phase();
    for (int i = 0; i < 10; i++) step(1'b1, i == 0, DW'(i + 1));
    do_reset();
    send_frame(0, 1'b0);
    end_phase("rst_mid", 4, 1);
    check_win("rst_mid_first", seen[0], WinFirst);
    check_win("rst_mid_last", seen[3], WinLast);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
